// File: rtl/scurve_sweep_engine.sv
// rtl/scurve_sweep_engine.sv - S-curve threshold sweep sequencer with framed USB FIFO output
module scurve_sweep_engine #(
  parameter int CHN_NUM   = 64,
  parameter int CHN_WIDTH = 6,
  parameter int DAC_WIDTH = 10,
  parameter int CNT_WIDTH = 16,
  parameter int TRIG_NUM  = 3
) (
  input  logic                 Clk,
  input  logic                 reset,
  input  logic                 Test_Start,
  input  logic                 Test_Abort,
  input  logic                 Single_or_AllChn,
  input  logic [CHN_WIDTH-1:0] SingleTest_Chn,
  input  logic [DAC_WIDTH-1:0] Dac_Start,
  input  logic [DAC_WIDTH-1:0] Dac_Stop,
  input  logic [DAC_WIDTH-1:0] Dac_Step,
  input  logic [CNT_WIDTH-1:0] CPT_MAX,
  input  logic [1:0]           Trig_Sel,
  input  logic [TRIG_NUM-1:0]  trigger_b,
  input  logic                 CLK_EXT,
  input  logic                 Microroc_Config_Done,
  output logic                 SC_Param_Load,
  output logic [CHN_NUM-1:0]   Microroc_CTest_Chn_Out,
  output logic [DAC_WIDTH-1:0] Microroc_DAC_Out,
  input  logic                 usb_data_fifo_full,
  output logic                 usb_data_fifo_wr_en,
  output logic [15:0]          usb_data_fifo_wr_din,
  output logic                 Test_Busy,
  output logic                 SCurve_Test_Done
);

  typedef enum logic [3:0] {
    S_IDLE, S_HEADER, S_LOAD, S_WAIT_CFG, S_COUNT,
    S_WR_ID, S_WR_WIN, S_WR_TRIG, S_TAIL, S_DONE
  } state_t;

  localparam logic [CHN_NUM-1:0]   LP_ONE_HOT  = CHN_NUM'(1);
  localparam logic [CHN_WIDTH-1:0] LP_CHN_LAST = CHN_WIDTH'(CHN_NUM - 1);

  state_t               r_state;
  logic [2:0]           r_ext_sync;
  logic                 r_ext_edge;
  logic [TRIG_NUM-1:0]  r_trg_s1, r_trg_s2, r_trg_s3, r_trg_edge;
  logic [CHN_WIDTH-1:0] r_chn, r_chn_last;
  logic [DAC_WIDTH-1:0] r_dac, r_dac_start, r_dac_stop, r_dac_step;
  logic [CNT_WIDTH-1:0] r_cpt, r_win, r_trig;
  logic [1:0]           r_sel;
  logic                 r_busy, r_done, r_load;
  logic [CHN_NUM-1:0]   r_ctest;
  logic [DAC_WIDTH-1:0] r_dac_out;

  logic                 w_sel_edge;
  logic [DAC_WIDTH:0]   w_dac_sum;
  logic                 w_dac_more, w_chn_more;
  logic [CNT_WIDTH-1:0] w_win_inc;
  logic                 w_wr_state, w_wr_fire;
  logic [15:0]          w_wr_din;
  logic [CHN_WIDTH-1:0] w_single_chn;
  logic [1:0]           w_sel;

  // Two-flop synchronisers followed by a registered edge detect (3-cycle event latency)
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      r_ext_sync <= '0;
      r_ext_edge <= 1'b0;
      r_trg_s1   <= '1;
      r_trg_s2   <= '1;
      r_trg_s3   <= '1;
      r_trg_edge <= '0;
    end else begin
      r_ext_sync <= {r_ext_sync[1:0], CLK_EXT};
      r_ext_edge <= r_ext_sync[1] & ~r_ext_sync[2];
      r_trg_s1   <= trigger_b;
      r_trg_s2   <= r_trg_s1;
      r_trg_s3   <= r_trg_s2;
      r_trg_edge <= r_trg_s3 & ~r_trg_s2;
    end
  end

  always_comb begin
    w_sel_edge = 1'b0;
    for (int i = 0; i < TRIG_NUM; i++) begin
      if (r_sel == i[1:0]) w_sel_edge = r_trg_edge[i];
    end
  end

  assign w_dac_sum    = {1'b0, r_dac} + {1'b0, r_dac_step};
  assign w_dac_more   = !w_dac_sum[DAC_WIDTH] && (w_dac_sum[DAC_WIDTH-1:0] <= r_dac_stop);
  assign w_chn_more   = (r_chn != r_chn_last);
  assign w_win_inc    = r_win + CNT_WIDTH'(1);
  assign w_single_chn = (int'(SingleTest_Chn) >= CHN_NUM) ? LP_CHN_LAST : SingleTest_Chn;
  assign w_sel        = (int'(Trig_Sel) >= TRIG_NUM) ? 2'd0 : Trig_Sel;

  assign w_wr_state = (r_state == S_HEADER) || (r_state == S_WR_ID) || (r_state == S_WR_WIN) ||
                      (r_state == S_WR_TRIG) || (r_state == S_TAIL);
  // An abort in the same cycle drops the pending write
  assign w_wr_fire  = w_wr_state && !usb_data_fifo_full && !Test_Abort;

  always_comb begin
    w_wr_din = 16'h0000;
    case (r_state)
      S_HEADER:  w_wr_din = 16'h5343;
      S_WR_ID:   w_wr_din = 16'({r_chn, r_dac});
      S_WR_WIN:  w_wr_din = 16'(r_win);
      S_WR_TRIG: w_wr_din = 16'(r_trig);
      S_TAIL:    w_wr_din = 16'h4544;
      default:   w_wr_din = 16'h0000;
    endcase
  end

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_chn       <= '0;
      r_chn_last  <= '0;
      r_dac       <= '0;
      r_dac_start <= '0;
      r_dac_stop  <= '0;
      r_dac_step  <= '0;
      r_cpt       <= '0;
      r_win       <= '0;
      r_trig      <= '0;
      r_sel       <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_load      <= 1'b0;
      r_ctest     <= '0;
      r_dac_out   <= '0;
    end else if ((r_state != S_IDLE) && Test_Abort) begin
      r_state   <= S_IDLE;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_load    <= 1'b0;
      r_ctest   <= '0;
      r_dac_out <= '0;
    end else begin
      r_load <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: if (Test_Start) begin
          r_chn       <= Single_or_AllChn ? '0 : w_single_chn;
          r_chn_last  <= Single_or_AllChn ? LP_CHN_LAST : w_single_chn;
          r_dac       <= Dac_Start;
          r_dac_start <= Dac_Start;
          r_dac_stop  <= Dac_Stop;
          r_dac_step  <= (Dac_Step == '0) ? DAC_WIDTH'(1) : Dac_Step;
          r_cpt       <= CPT_MAX;
          r_sel       <= w_sel;
          r_busy      <= 1'b1;
          r_state     <= S_HEADER;
        end
        S_HEADER: if (w_wr_fire) r_state <= S_LOAD;
        S_LOAD: begin
          r_ctest   <= LP_ONE_HOT << r_chn;
          r_dac_out <= r_dac;
          r_load    <= 1'b1;
          r_state   <= S_WAIT_CFG;
        end
        S_WAIT_CFG: if (Microroc_Config_Done) begin
          r_win   <= '0;
          r_trig  <= '0;
          r_state <= S_COUNT;
        end
        S_COUNT: begin
          if (r_cpt == '0) begin
            r_state <= S_WR_ID;
          end else begin
            if (r_ext_edge) r_win <= w_win_inc;
            if (w_sel_edge && (r_trig != '1)) r_trig <= r_trig + CNT_WIDTH'(1);
            if (r_ext_edge && (w_win_inc == r_cpt)) r_state <= S_WR_ID;
          end
        end
        S_WR_ID:  if (w_wr_fire) r_state <= S_WR_WIN;
        S_WR_WIN: if (w_wr_fire) r_state <= S_WR_TRIG;
        S_WR_TRIG: if (w_wr_fire) begin
          if (w_dac_more) begin
            r_dac   <= w_dac_sum[DAC_WIDTH-1:0];
            r_state <= S_LOAD;
          end else if (w_chn_more) begin
            r_chn   <= r_chn + CHN_WIDTH'(1);
            r_dac   <= r_dac_start;
            r_state <= S_LOAD;
          end else begin
            r_state <= S_TAIL;
          end
        end
        S_TAIL: if (w_wr_fire) begin
          r_done  <= 1'b1;
          r_state <= S_DONE;
        end
        S_DONE: begin
          r_busy    <= 1'b0;
          r_ctest   <= '0;
          r_dac_out <= '0;
          r_state   <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign SC_Param_Load          = r_load;
  assign Microroc_CTest_Chn_Out = r_ctest;
  assign Microroc_DAC_Out       = r_dac_out;
  assign usb_data_fifo_wr_en    = w_wr_fire;
  assign usb_data_fifo_wr_din   = w_wr_din;
  assign Test_Busy              = r_busy;
  assign SCurve_Test_Done       = r_done;

endmodule
